core_run_ctrl: RTL and testbench

Boot/run/dump sequencer for the single-cycle RV32I core. It streams a program into instruction memory while the core is held in reset, then releases the core. It stops the core on a halt instruction or on a cycle limit, and dumps all 32 architectural registers over a valid/ready stream. It sits between the bench or host loader and `RISC_V_RV32I_Top_Module`. The core's PC register, RegWrite and MemWrite honour `core_en`.

---
 rtl/core_run_ctrl_if.sv | 21 ++
 rtl/core_run_ctrl.sv | 177 +++++++++++++++++
 tb/tb_core_run_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_run_ctrl_if.sv
// Load and dump streams of the core run controller.
// master = host/bench side, slave = controller side.
interface core_run_ctrl_if;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        dump_valid;
    logic [31:0] dump_data;
    logic        dump_ready;

    modport master (
        output ld_valid, ld_data, ld_last, dump_ready,
        input  ld_ready, dump_valid, dump_data
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, dump_ready,
        output ld_ready, dump_valid, dump_data
    );
endinterface

// File: rtl/core_run_ctrl.sv
// Boot/run/dump sequencer for the RV32I core.
// Ports: clk/rst, bus (load + dump streams), imem write port,
// start/cycle_limit, core_instr/core_rst/core_en, register-file
// debug port, cycles/done/timeout/state status.
module core_run_ctrl #(
    parameter int IMEM_WORDS = 64,
    parameter int ADDR_W     = 6,
    parameter int CYC_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    core_run_ctrl_if.slave    bus,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              start,
    input  logic [CYC_W-1:0]  cycle_limit,
    input  logic [31:0]       core_instr,
    output logic              core_rst,
    output logic              core_en,
    output logic [4:0]        dbg_rf_addr,
    input  logic [31:0]       dbg_rf_data,
    output logic [CYC_W-1:0]  cycles,
    output logic              done,
    output logic              timeout,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_READY = 3'd1,
        S_RUN   = 3'd2,
        S_DUMP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [4:0]        r_dump_ptr;
    logic [CYC_W-1:0]  r_cycles;
    logic              r_timeout;

    logic              w_ld_ready;
    logic              w_dump_valid;
    logic              w_core_rst;
    logic              w_core_en;
    logic              w_done;
    logic              w_ld_hs;
    logic              w_dump_hs;
    logic              w_halt;
    logic              w_last_slot;
    logic              w_limit_hit;
    logic [CYC_W:0]    w_cyc_inc;
    logic [CYC_W-1:0]  w_cyc_sat;

    assign w_ld_hs     = bus.ld_valid & w_ld_ready;
    assign w_dump_hs   = w_dump_valid & bus.dump_ready;
    assign w_halt      = (core_instr == 32'h0000_0073) ||
                         (core_instr == 32'h0000_006F);
    assign w_last_slot = (r_wr_ptr == ADDR_W'(IMEM_WORDS - 1));

    // One bit wider so the limit compare never sees a wrapped count.
    assign w_cyc_inc   = {1'b0, r_cycles} + 1'b1;
    assign w_cyc_sat   = (&r_cycles) ? r_cycles : w_cyc_inc[CYC_W-1:0];
    assign w_limit_hit = (cycle_limit != '0) &&
                         (w_cyc_inc == {1'b0, cycle_limit});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_ld_ready   = 1'b0;
        w_dump_valid = 1'b0;
        w_core_rst   = 1'b0;
        w_core_en    = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            S_LOAD: begin
                w_ld_ready = 1'b1;
                w_core_rst = 1'b1;
                if (bus.ld_valid && (bus.ld_last || w_last_slot)) begin
                    w_next = S_READY;
                end
            end
            S_READY: begin
                w_core_rst = 1'b1;
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                w_core_en = 1'b1;
                if (w_halt || w_limit_hit) begin
                    w_next = S_DUMP;
                end
            end
            S_DUMP: begin
                w_dump_valid = 1'b1;
                if (bus.dump_ready && (r_dump_ptr == 5'd31)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_next = S_LOAD;
                end
            end
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_dump_ptr <= '0;
            r_cycles   <= '0;
            r_timeout  <= 1'b0;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    if (w_ld_hs) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                end
                S_READY: begin
                    if (start) begin
                        r_cycles <= '0;
                    end
                end
                S_RUN: begin
                    r_cycles <= w_cyc_sat;
                    // A halt on the limit cycle is a normal stop.
                    if (!w_halt && w_limit_hit) begin
                        r_timeout <= 1'b1;
                    end
                end
                S_DUMP: begin
                    // Wraps to 0 after x31, ready for the next dump.
                    if (w_dump_hs) begin
                        r_dump_ptr <= r_dump_ptr + 1'b1;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        r_wr_ptr  <= '0;
                        r_cycles  <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ld_ready   = w_ld_ready;
    assign bus.dump_valid = w_dump_valid;
    assign bus.dump_data  = dbg_rf_data;
    assign imem_we        = w_ld_hs;
    assign imem_addr      = r_wr_ptr;
    assign imem_wdata     = bus.ld_data;
    assign core_rst       = w_core_rst;
    assign core_en        = w_core_en;
    assign dbg_rf_addr    = r_dump_ptr;
    assign cycles         = r_cycles;
    assign done           = w_done;
    assign timeout        = r_timeout;
    assign state          = r_state;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl with a tiny RV32I core model.
// Scoreboards check imem writes and dump beats.
module tb_core_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        start;
    logic [15:0] cycle_limit;
    logic [31:0] core_instr;
    logic        core_rst;
    logic        core_en;
    logic [4:0]  dbg_rf_addr;
    logic [31:0] dbg_rf_data;
    logic [15:0] cycles;
    logic        done;
    logic        timeout;
    logic [2:0]  state;

    core_run_ctrl_if bus ();

    core_run_ctrl #(.IMEM_WORDS(64), .ADDR_W(6), .CYC_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .start(start),
        .cycle_limit(cycle_limit), .core_instr(core_instr),
        .core_rst(core_rst), .core_en(core_en),
        .dbg_rf_addr(dbg_rf_addr), .dbg_rf_data(dbg_rf_data),
        .cycles(cycles), .done(done), .timeout(timeout),
        .state(state)
    );

    always #5 clk = ~clk;

    // Core model: addi, add, jal; anything else just advances.
    logic [31:0] imem [0:63];
    logic [31:0] rf   [0:31];
    logic [5:0]  pc;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_j;

    assign core_instr  = imem[pc];
    assign dbg_rf_data = rf[dbg_rf_addr];
    assign op    = core_instr[6:0];
    assign rd    = core_instr[11:7];
    assign f3    = core_instr[14:12];
    assign rs1   = core_instr[19:15];
    assign rs2   = core_instr[24:20];
    assign imm_i = {{20{core_instr[31]}}, core_instr[31:20]};
    assign imm_j = {{12{core_instr[31]}}, core_instr[19:12],
                    core_instr[20], core_instr[30:21], 1'b0};

    always @(posedge clk) begin
        if (imem_we) imem[imem_addr] <= imem_wdata;
        if (core_rst) begin
            pc <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (core_en) begin
            pc <= pc + 6'd1;
            if (op == 7'h13 && f3 == 3'd0 && rd != 5'd0)
                rf[rd] <= rf[rs1] + imm_i;
            else if (op == 7'h33 && f3 == 3'd0 && rd != 5'd0)
                rf[rd] <= rf[rs1] + rf[rs2];
            else if (op == 7'h6F) begin
                if (rd != 5'd0) rf[rd] <= {24'd0, pc + 6'd1, 2'b00};
                pc <= pc + imm_j[7:2];
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int n_writes = 0;
    int beats = 0;
    logic [37:0] wq [$];
    logic [31:0] dq [$];
    logic [37:0] wexp;
    logic [31:0] dexp;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data;
    logic [4:0]  prev_addr;
    logic [31:0] prog [0:69];

    always @(negedge clk) begin
        if (imem_we) begin
            n_writes++;
            n_vec++;
            if (wq.size() == 0) begin
                n_err++;
                $display("FAIL imem_wr unexpected addr=%0d data=%h",
                         imem_addr, imem_wdata);
            end else begin
                wexp = wq.pop_front();
                if ({imem_addr, imem_wdata} !== wexp) begin
                    n_err++;
                    $display("FAIL imem_wr got %0d/%h want %0d/%h",
                             imem_addr, imem_wdata, wexp[37:32], wexp[31:0]);
                end
            end
        end
        if (prev_hold && bus.dump_valid) begin
            n_vec++;
            if (bus.dump_data !== prev_data || dbg_rf_addr !== prev_addr) begin
                n_err++;
                $display("FAIL dump_hold got %h@%0d want %h@%0d",
                         bus.dump_data, dbg_rf_addr, prev_data, prev_addr);
            end
        end
        if (bus.dump_valid && bus.dump_ready) begin
            n_vec++;
            if (dq.size() == 0) begin
                n_err++;
                $display("FAIL dump_beat unexpected data=%h", bus.dump_data);
            end else begin
                dexp = dq.pop_front();
                if (bus.dump_data !== dexp ||
                    dbg_rf_addr !== 5'(beats % 32)) begin
                    n_err++;
                    $display("FAIL dump_beat got %h@x%0d want %h@x%0d",
                             bus.dump_data, dbg_rf_addr, dexp, beats % 32);
                end
            end
            beats++;
        end
        prev_hold = bus.dump_valid && !bus.dump_ready;
        prev_data = bus.dump_data;
        prev_addr = dbg_rf_addr;
    end

    task automatic push_dump(input logic [31:0] x1, x2, x3);
        for (int i = 0; i < 32; i++)
            dq.push_back(i == 1 ? x1 : i == 2 ? x2 : i == 3 ? x3 : 32'd0);
    endtask

    task automatic set_prog1();
        prog[0] = 32'h00500093;
        prog[1] = 32'h00A00113;
        prog[2] = 32'h002081B3;
        prog[3] = 32'h00000073;
    endtask

    task automatic load_prog(input int n, input bit last, input bit poke);
        for (int i = 0; i < n; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = prog[i];
            bus.ld_last  = last && (i == n - 1);
            start = poke && (i == 1);
            if (i < 64) wq.push_back({6'(i), prog[i]});
            @(negedge clk);
            if (i >= 64) begin
                n_vec++;
                if (bus.ld_ready !== 1'b0 || imem_we !== 1'b0) begin
                    n_err++;
                    $display("FAIL overflow_ready w%0d got %b/%b want 0/0",
                             i, bus.ld_ready, imem_we);
                end
            end
            @(posedge clk); #1;
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        start = 1'b0;
        @(negedge clk);
        n_vec++;
        if (state !== 3'd1 || core_rst !== 1'b1 || bus.ld_ready !== 1'b0) begin
            n_err++;
            $display("FAIL load_ready got st=%0d rst=%b rdy=%b want 1/1/0",
                     state, core_rst, bus.ld_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_and_dump(input bit bp, input bit poke);
        bit ok;
        ok = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (state == 3'd4) begin
                ok = 1'b1;
                break;
            end
            bus.dump_ready = bp ? (c % 3 == 0) : 1'b1;
            start = poke && (c % 4 == 1);
            @(posedge clk); #1;
        end
        start = 1'b0;
        bus.dump_ready = 1'b1;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL run_done got st=%0d want 4 within 400", state);
        end
    endtask

    task automatic check_end(input string nm, input logic [15:0] cyc,
                             input logic to, input int b0);
        @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || cycles !== cyc || timeout !== to ||
            beats - b0 != 32 || dq.size() != 0 || core_en !== 1'b0) begin
            n_err++;
            $display("FAIL %s got d=%b cyc=%0d to=%b beats=%0d q=%0d want 1/%0d/%b/32/0",
                     nm, done, cycles, timeout, beats - b0, dq.size(), cyc, to);
        end
        @(posedge clk); #1;
    endtask

    task automatic go_load();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_vec++;
        if (state !== 3'd0 || cycles !== 16'd0 || timeout !== 1'b0 ||
            done !== 1'b0 || core_rst !== 1'b1) begin
            n_err++;
            $display("FAIL restart got st=%0d cyc=%0d to=%b d=%b crst=%b",
                     state, cycles, timeout, done, core_rst);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        cycle_limit = '0;
        bus.ld_valid = 1'b0;
        bus.ld_data = '0;
        bus.ld_last = 1'b0;
        bus.dump_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (state !== 3'd0 || core_rst !== 1'b1 || core_en !== 1'b0 ||
            bus.ld_ready !== 1'b1 || done !== 1'b0 || cycles !== 16'd0 ||
            timeout !== 1'b0 || bus.dump_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset got st=%0d crst=%b en=%b rdy=%b d=%b cyc=%0d",
                     state, core_rst, core_en, bus.ld_ready, done, cycles);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int b0;
        set_prog1();
        load_prog(4, 1'b1, 1'b0);
        push_dump(32'h5, 32'hA, 32'hF);
        b0 = beats;
        run_and_dump(1'b0, 1'b0);
        check_end("basic", 16'd4, 1'b0, b0);
    endtask

    task automatic test_timeout();
        int b0;
        go_load();
        prog[0] = 32'h00108093;
        prog[1] = 32'hFFDFF06F;
        load_prog(2, 1'b1, 1'b0);
        cycle_limit = 16'd20;
        push_dump(32'hA, 32'h0, 32'h0);
        b0 = beats;
        run_and_dump(1'b0, 1'b0);
        check_end("timeout", 16'd20, 1'b1, b0);
        cycle_limit = '0;
    endtask

    task automatic test_overflow();
        int w0, b0;
        go_load();
        for (int i = 0; i < 70; i++)
            prog[i] = (i == 0) ? 32'h00000073 : (32'h13 | (i << 20));
        w0 = n_writes;
        load_prog(70, 1'b0, 1'b0);
        n_vec++;
        if (n_writes - w0 != 64 || wq.size() != 0) begin
            n_err++;
            $display("FAIL overflow_count got %0d q=%0d want 64/0",
                     n_writes - w0, wq.size());
        end
        push_dump(32'h0, 32'h0, 32'h0);
        b0 = beats;
        run_and_dump(1'b0, 1'b0);
        check_end("overflow_run", 16'd1, 1'b0, b0);
    endtask

    task automatic test_backpressure();
        int b0;
        go_load();
        set_prog1();
        load_prog(4, 1'b1, 1'b0);
        push_dump(32'h5, 32'hA, 32'hF);
        b0 = beats;
        run_and_dump(1'b1, 1'b0);
        check_end("backpressure", 16'd4, 1'b0, b0);
    endtask

    task automatic test_rst_mid_run();
        int b0;
        go_load();
        set_prog1();
        load_prog(4, 1'b1, 1'b0);
        b0 = beats;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (state !== 3'd2 || cycles !== 16'd1) begin
            n_err++;
            $display("FAIL run2 got st=%0d cyc=%0d want 2/1", state, cycles);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (state !== 3'd0 || core_rst !== 1'b1 || cycles !== 16'd0 ||
            done !== 1'b0 || bus.dump_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_rst got st=%0d crst=%b cyc=%0d d=%b dv=%b",
                     state, core_rst, cycles, done, bus.dump_valid);
        end
        repeat (40) @(posedge clk);
        #1;
        n_vec++;
        if (beats != b0 || state !== 3'd0) begin
            n_err++;
            $display("FAIL mid_rst_idle got beats=%0d st=%0d want 0/0",
                     beats - b0, state);
        end
    endtask

    task automatic test_restart();
        int b0;
        set_prog1();
        load_prog(4, 1'b1, 1'b0);
        push_dump(32'h5, 32'hA, 32'hF);
        b0 = beats;
        run_and_dump(1'b0, 1'b0);
        check_end("restart_a", 16'd4, 1'b0, b0);
        go_load();
        load_prog(4, 1'b1, 1'b1);
        push_dump(32'h5, 32'hA, 32'hF);
        b0 = beats;
        run_and_dump(1'b0, 1'b1);
        check_end("restart_b", 16'd4, 1'b0, b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_overflow();
        test_backpressure();
        test_rst_mid_run();
        test_restart();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
